// File: rtl/sap_ram_unit.sv
// SAP memory block: MAR plus DEPTH x DATA_W RAM on the CPU bus, with a post-reset
// clear sequence and a PROG mode that streams loader bytes into RAM.
module sap_ram_unit #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned ADDR_W         = 4,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus,
    input  logic              load_mar,
    input  logic              inc_mar,
    input  logic              we,
    input  logic              prog_en,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] mar_out,
    output logic [DATA_W-1:0] out
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_PROG  = 2'd2
    } state_t;

    localparam state_t RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;
    localparam logic   RST_BUSY  = CLEAR_ON_RESET;

    state_t            state;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] ram [DEPTH];

    logic              ram_wr_c;
    logic [ADDR_W-1:0] ram_addr_c;
    logic [DATA_W-1:0] ram_wdata_c;

    // RAM write port: clear sweep, CPU write, or accepted loader beat
    always_comb begin
        ram_wr_c    = 1'b0;
        ram_addr_c  = mar;
        ram_wdata_c = bus;
        unique case (state)
            S_CLEAR: begin
                ram_wr_c    = 1'b1;
                ram_addr_c  = clr_cnt;
                ram_wdata_c = '0;
            end
            S_RUN:   ram_wr_c = we && !prog_en;
            S_PROG: begin
                ram_wr_c    = prog_en && prog_valid;
                ram_wdata_c = prog_data;
            end
            default: ram_wr_c = 1'b0;
        endcase
    end

    // Control FSM, MAR and clear counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RST_STATE;
            mar     <= '0;
            clr_cnt <= '0;
            busy    <= RST_BUSY;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (prog_en) begin
                        state <= S_PROG;
                        busy  <= 1'b1;
                        mar   <= '0;
                    end else if (load_mar) begin
                        mar <= bus[ADDR_W-1:0];
                    end else if (inc_mar) begin
                        mar <= mar + ADDR_W'(1);
                    end
                end
                S_PROG: begin
                    if (!prog_en) begin
                        state <= S_RUN;
                        busy  <= 1'b0;
                        mar   <= '0;
                    end else if (prog_valid) begin
                        mar <= mar + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= RST_STATE;
                    busy  <= RST_BUSY;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; the CLEAR state zeroes it instead
    always_ff @(posedge clk) begin
        if (ram_wr_c) ram[ram_addr_c] <= ram_wdata_c;
    end

    // Ready follows prog_en only while in PROG, so it falls with the async reset
    assign prog_ready = (state == S_PROG) && prog_en;
    assign mar_out    = mar;
    assign out        = ram[mar];

endmodule

// File: tb/tb_sap_ram_unit.sv
// Directed bench for sap_ram_unit: default instance (8/4, clear on reset) and a
// 16/6 instance without clear.
module tb_sap_ram_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus;
    logic       load_mar, inc_mar, we, prog_en, prog_valid;
    logic [7:0] prog_data;
    logic       prog_ready, busy;
    logic [3:0] mar_out;
    logic [7:0] out;

    logic        rst2;
    logic [15:0] bus2;
    logic        load2, inc2, we2;
    logic [15:0] pdata2;
    logic        pready2, busy2;
    logic [5:0]  mar2;
    logic [15:0] out2;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sap_ram_unit dut (
        .clk(clk), .rst(rst), .bus(bus), .load_mar(load_mar), .inc_mar(inc_mar),
        .we(we), .prog_en(prog_en), .prog_valid(prog_valid), .prog_data(prog_data),
        .prog_ready(prog_ready), .busy(busy), .mar_out(mar_out), .out(out)
    );

    sap_ram_unit #(.DATA_W(16), .ADDR_W(6), .CLEAR_ON_RESET(1'b0)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2), .load_mar(load2), .inc_mar(inc2),
        .we(we2), .prog_en(1'b0), .prog_valid(1'b0), .prog_data(pdata2),
        .prog_ready(pready2), .busy(busy2), .mar_out(mar2), .out(out2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus = '0; load_mar = 0; inc_mar = 0; we = 0;
        prog_valid = 0; prog_data = '0;
    endtask

    // Release reset and count the cycles busy stays high
    task automatic release_and_count(input string tag);
        int n;
        rst = 1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'd16);
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            bus = 8'(i); load_mar = 1; tick();
            chk({tag, "_out"}, 32'(out), 32'h00);
        end
        load_mar = 0;
    endtask

    initial begin
        rst = 0; rst2 = 0; prog_en = 0;
        idle();
        bus2 = '0; load2 = 0; inc2 = 0; we2 = 0; pdata2 = '0;
        tick(); tick();

        // 1: reset state, clear sequence length, all zero
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_mar", 32'(mar_out), 32'd0);
        chk("rst_ready", 32'(prog_ready), 32'd0);
        release_and_count("clear_len");
        sweep_zero("clear1");

        // 2: basic write/read
        bus = 8'h05; load_mar = 1; tick();
        load_mar = 0; bus = 8'hA7; we = 1; tick();
        we = 0;
        chk("wr_a7", 32'(out), 32'hA7);
        bus = 8'h06; load_mar = 1; tick();
        chk("rd_06", 32'(out), 32'h00);
        bus = 8'hF5; tick();
        chk("load_f5_mar", 32'(mar_out), 32'h5);
        chk("load_f5_out", 32'(out), 32'hA7);

        // 3: write+load same cycle, load over inc, inc wrap
        bus = 8'h02; tick();
        bus = 8'h13; we = 1; tick();
        we = 0;
        chk("wl_mar", 32'(mar_out), 32'h3);
        bus = 8'h02; tick();
        chk("wl_ram2", 32'(out), 32'h13);
        bus = 8'h09; inc_mar = 1; tick();
        chk("load_prio", 32'(mar_out), 32'h9);
        inc_mar = 0; bus = 8'h0F; tick();
        load_mar = 0; inc_mar = 1; tick();
        inc_mar = 0;
        chk("inc_wrap", 32'(mar_out), 32'h0);

        // 4: PROG load with gaps; CPU controls asserted during gaps must be ignored
        bus = 8'h04; prog_en = 1; we = 1; tick();
        we = 0;
        chk("prog_busy", 32'(busy), 32'd1);
        chk("prog_mar0", 32'(mar_out), 32'd0);
        chk("prog_ready", 32'(prog_ready), 32'd1);
        for (int i = 0; i < 17; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                prog_valid = 0; prog_data = 8'h55;
                bus = 8'h77; we = 1; load_mar = 1; inc_mar = 1;
                tick();
            end
            we = 0; load_mar = 0; inc_mar = 0;
            prog_valid = 1; prog_data = (i == 16) ? 8'hEE : 8'(8'h10 + i);
            tick();
        end
        prog_valid = 1; prog_data = 8'h55; prog_en = 0;
        #1;
        chk("exit_ready", 32'(prog_ready), 32'd0);
        tick();
        prog_valid = 0;
        chk("exit_busy", 32'(busy), 32'd0);
        chk("exit_mar", 32'(mar_out), 32'd0);
        chk("beat17", 32'(out), 32'hEE);
        for (int i = 1; i < 16; i++) begin
            bus = 8'(i); load_mar = 1; tick();
            chk("prog_data", 32'(out), 32'(8'h10 + i));
        end
        load_mar = 0;

        // 5: reset in the middle of PROG; writes during CLEAR ignored
        prog_en = 1; tick();
        for (int i = 0; i < 5; i++) begin
            prog_valid = 1; prog_data = 8'(8'h30 + i); tick();
        end
        prog_valid = 0;
        chk("mid_ready", 32'(prog_ready), 32'd1);
        #1 rst = 0;
        #1;
        chk("abort_ready", 32'(prog_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_mar", 32'(mar_out), 32'd0);
        prog_en = 0;
        tick();
        bus = 8'h5A; we = 1; load_mar = 1;
        release_and_count("clear2_len");
        chk("clear2_mar", 32'(mar_out), 32'd0);
        idle();
        sweep_zero("clear2");

        // 6: wide instance without clear
        chk("w_rst_busy", 32'(busy2), 32'd0);
        rst2 = 1; tick();
        chk("w_busy", 32'(busy2), 32'd0);
        bus2 = 16'h003F; load2 = 1; tick();
        load2 = 0; bus2 = 16'hBEEF; we2 = 1; tick();
        we2 = 0;
        chk("w_mar", 32'(mar2), 32'h3F);
        chk("w_out", 32'(out2), 32'hBEEF);
        inc2 = 1; tick();
        inc2 = 0;
        chk("w_wrap", 32'(mar2), 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
